muldiv_seq_unit: RTL

Parametrised multi-cycle arithmetic unit for the processor execute stage. It performs multiply, divide and shift on two register operands.
- Multiply and divide are iterative radix-2 over WIDTH cycles, with signed and unsigned modes and a full double-width result (high product or remainder).
- Shifts are exact-amount SHL, SHR and SAR.
- A start/busy/done handshake tells the pipeline when to stall and when to write back.
- Divide-by-zero is flagged for the exception collector.

---
 rtl/muldiv_seq_unit.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq_unit.sv
// Multi-cycle multiply / divide / shift unit for the execute stage.
// MUL and DIV iterate one bit per cycle (shift-add and restoring divide)
// on operand magnitudes, then fix up signs in a final cycle. Shifts,
// divide-by-zero and illegal opcodes complete in a single short cycle.
module muldiv_seq_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             signed_md,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_DIV = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_SAR = 3'b100;

  localparam logic [WIDTH-1:0] W_LIMIT  = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIX   = 2'd2,
    S_SHORT = 2'd3
  } state_t;

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = ~v + WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Double-width conditional negate for the full product.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    logic [2*WIDTH-1:0] r;
    if (en) begin
      r = ~v + (2*WIDTH)'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t             state_r;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   opnd_r;    // MUL: |a|, DIV: |b|, shifts: raw b
  logic [WIDTH-1:0]   acc_hi_r;  // MUL: partial product high, DIV: remainder
  logic [WIDTH-1:0]   acc_lo_r;  // MUL: multiplier/product low, DIV: dividend/quotient, shifts: raw a
  logic               neg_q_r;
  logic               neg_r_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic               is_md_s;
  logic               b_zero_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   step_hi_s;
  logic [WIDTH-1:0]   step_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_lo_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [SH_W-1:0]    shamt_s;
  logic               in_range_s;
  logic [WIDTH-1:0]   short_lo_s;
  logic [WIDTH-1:0]   short_hi_s;
  logic               short_dbz_s;

  // Operand decode at the start edge: magnitudes for signed MUL/DIV.
  always_comb begin
    a_neg_s  = signed_md & a[WIDTH-1];
    b_neg_s  = signed_md & b[WIDTH-1];
    a_mag_s  = neg_w(a, a_neg_s);
    b_mag_s  = neg_w(b, b_neg_s);
    is_md_s  = (op == OP_MUL) || (op == OP_DIV);
    b_zero_s = (b == {WIDTH{1'b0}});
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    if (op_r == OP_MUL) begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
    end else begin
      step_hi_s = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
      step_lo_s = {acc_lo_r[WIDTH-2:0], div_ge_s};
    end
  end

  // Final sign correction; remainder takes the sign of the dividend.
  always_comb begin
    prod_s = neg_2w({acc_hi_r, acc_lo_r}, neg_q_r);
    if (op_r == OP_MUL) begin
      fix_lo_s = prod_s[WIDTH-1:0];
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    end else begin
      fix_lo_s = neg_w(acc_lo_r, neg_q_r);
      fix_hi_s = neg_w(acc_hi_r, neg_r_r);
    end
  end

  // Single-cycle results: shifts, divide by zero, illegal opcodes.
  always_comb begin
    shamt_s     = opnd_r[SH_W-1:0];
    in_range_s  = (opnd_r < W_LIMIT);
    short_lo_s  = {WIDTH{1'b0}};
    short_hi_s  = {WIDTH{1'b0}};
    short_dbz_s = 1'b0;
    case (op_r)
      OP_SHL: begin
        if (in_range_s) begin
          short_lo_s = acc_lo_r << shamt_s;
        end else begin
          short_lo_s = {WIDTH{1'b0}};
        end
      end
      OP_SHR: begin
        if (in_range_s) begin
          short_lo_s = acc_lo_r >> shamt_s;
        end else begin
          short_lo_s = {WIDTH{1'b0}};
        end
      end
      OP_SAR: begin
        if (in_range_s) begin
          short_lo_s = $unsigned($signed(acc_lo_r) >>> shamt_s);
        end else begin
          short_lo_s = {WIDTH{acc_lo_r[WIDTH-1]}};
        end
      end
      OP_DIV: begin
        short_lo_s  = {WIDTH{1'b1}};
        short_hi_s  = acc_lo_r;
        short_dbz_s = 1'b1;
      end
      default: begin
        short_lo_s  = {WIDTH{1'b0}};
        short_hi_s  = {WIDTH{1'b0}};
        short_dbz_s = 1'b0;
      end
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      op_r        <= 3'b000;
      opnd_r      <= {WIDTH{1'b0}};
      acc_hi_r    <= {WIDTH{1'b0}};
      acc_lo_r    <= {WIDTH{1'b0}};
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_lo   <= {WIDTH{1'b0}};
      result_hi   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          if (start) begin
            op_r     <= op;
            busy     <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            if (is_md_s && !((op == OP_DIV) && b_zero_s)) begin
              state_r <= S_RUN;
              neg_q_r <= a_neg_s ^ b_neg_s;
              neg_r_r <= a_neg_s;
              if (op == OP_MUL) begin
                opnd_r   <= a_mag_s;
                acc_lo_r <= b_mag_s;
              end else begin
                opnd_r   <= b_mag_s;
                acc_lo_r <= a_mag_s;
              end
            end else begin
              state_r  <= S_SHORT;
              neg_q_r  <= 1'b0;
              neg_r_r  <= 1'b0;
              opnd_r   <= b;
              acc_lo_r <= a;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_hi_r <= step_hi_s;
          acc_lo_r <= step_lo_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_FIX: begin
          result_lo <= fix_lo_s;
          result_hi <= fix_hi_s;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_r   <= S_IDLE;
        end
        S_SHORT: begin
          result_lo   <= short_lo_s;
          result_hi   <= short_hi_s;
          div_by_zero <= short_dbz_s;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_r     <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule
